// File: rtl/binary_div_pkg.sv
// Shared widths, FSM encoding and magnitude helpers for the 19/10 signed divider.
// Optional zero-operand bypass is selected in the top by BINARY_DIV_ZERO_BYPASS_EN.
package binary_div_pkg;

    localparam int unsigned N_W     = 19;
    localparam int unsigned D_W     = 10;
    localparam int unsigned LATENCY = 20;
    localparam int unsigned A_W     = N_W + 1;
    localparam int unsigned C_W     = 5;

    localparam logic signed [N_W-1:0] N_MIN = N_W'(-262144);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // |v| as unsigned; the most negative value maps onto its exact magnitude
    function automatic logic [N_W-1:0] mag_n(input logic [N_W-1:0] v);
        return v[N_W-1] ? (~v + N_W'(1)) : v;
    endfunction

    function automatic logic [D_W-1:0] mag_d(input logic [D_W-1:0] v);
        return v[D_W-1] ? (~v + D_W'(1)) : v;
    endfunction

endpackage

// File: rtl/binary_div_step.sv
// One restoring radix-2 step: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module binary_div_step
    import binary_div_pkg::*;
(
    input  logic [D_W-1:0] rem,
    input  logic [A_W-1:0] nq,
    input  logic [D_W-1:0] dmag,
    output logic [D_W-1:0] rem_nxt_c,
    output logic [A_W-1:0] nq_nxt_c
);

    logic [D_W:0] shifted;
    logic [D_W:0] diff;

    always_comb begin
        shifted   = {rem, nq[A_W-1]};
        diff      = shifted - {1'b0, dmag};
        rem_nxt_c = shifted[D_W-1:0];
        nq_nxt_c  = {nq[A_W-2:0], 1'b0};
        if (shifted >= {1'b0, dmag}) begin
            rem_nxt_c = diff[D_W-1:0];
            nq_nxt_c  = {nq[A_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/binary_div_19_10_bi.sv
// Sequential signed divider 19/10: truncating quotient, dividend-signed remainder.
// Define BINARY_DIV_ZERO_BYPASS_EN to skip the iteration when N==0 or D==0.
module binary_div_19_10_bi
    import binary_div_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  start,
    input  logic [N_W-1:0]        N,
    input  logic [D_W-1:0]        D,
    output logic [N_W-1:0]        Q,
    output logic [D_W-1:0]        R,
    output logic                  busy,
    output logic                  done,
    output logic                  dz,
    output logic                  ovf
);

    state_t         state;
    logic [C_W-1:0] cnt;
    logic [D_W-1:0] rem;
    logic [A_W-1:0] nq;
    logic [D_W-1:0] dmag;
    logic           sign_q;
    logic           sign_r;
    logic           dz_pend;

    logic [N_W-1:0] n_mag_c;
    logic [D_W-1:0] d_mag_c;
    logic [D_W-1:0] rem_nxt_c;
    logic [A_W-1:0] nq_nxt_c;
    logic [N_W-1:0] q_mag_c;
    logic           skip_c;

    assign n_mag_c = mag_n(N);
    assign d_mag_c = mag_d(D);
    // After 19 steps the pad bit has reached nq[19]; the quotient sits below it
    assign q_mag_c = nq[N_W-1:0];

`ifdef BINARY_DIV_ZERO_BYPASS_EN
    assign skip_c = (N == '0) || (D == '0);
`else
    assign skip_c = 1'b0;
`endif

    binary_div_step u_step (
        .rem       (rem),
        .nq        (nq),
        .dmag      (dmag),
        .rem_nxt_c (rem_nxt_c),
        .nq_nxt_c  (nq_nxt_c)
    );

    // Control FSM and datapath registers; en=0 freezes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            nq      <= '0;
            dmag    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            dz_pend <= 1'b0;
            Q       <= '0;
            R       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Low pad bit lets 19 steps consume exactly N's 19 magnitude bits
                        nq      <= {n_mag_c, 1'b0};
                        rem     <= '0;
                        dmag    <= d_mag_c;
                        sign_q  <= N[N_W-1] ^ D[D_W-1];
                        sign_r  <= N[N_W-1];
                        dz_pend <= (D == '0);
                        cnt     <= C_W'(LATENCY - 1);
                        busy    <= 1'b1;
                        state   <= skip_c ? FIX : CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nxt_c;
                    nq  <= nq_nxt_c;
                    cnt <= cnt - C_W'(1);
                    if (cnt == C_W'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (dz_pend) begin
                        Q   <= '0;
                        R   <= '0;
                        ovf <= 1'b0;
                    end else begin
                        Q   <= sign_q ? (~q_mag_c + N_W'(1)) : q_mag_c;
                        R   <= sign_r ? (~rem + D_W'(1)) : rem;
                        // Only +2^18 cannot be represented; it wraps to N_MIN
                        ovf <= ~sign_q & q_mag_c[N_W-1];
                    end
                    dz    <= dz_pend;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
